param_register_file: RTL and testbench

- Parametrised successor to the 32x32 PPU register file.
- Generalised data width and depth, with asynchronous reset of all registers and an optional hardwired-zero register 0.
- Adds a per-register busy scoreboard: issue reserves a destination, writeback clears it, so the decode stage can detect RAW hazards.
- Optional same-cycle write-to-read bypass.
- Sits between decode (read ports, reservation) and writeback (write port) in the PPU.

---
 rtl/param_register_file_if.sv | 49 ++++
 rtl/param_register_file.sv | 98 +++++++++
 tb/tb_param_register_file.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_register_file_if.sv
// -----------------------------------------------------------------------------
// param_register_file_if
// Bus bundle between the PPU decode/writeback stages and param_register_file.
//
// Parameters:
//   DATA_W  width of the PW/PA/PB data buses
//   ADDR_W  width of the register address fields
//
// Signals (direction given from the register file's point of view):
//   enable    in   write enable for the PW write port
//   RW        in   write address
//   PW        in   write data
//   RA, RB    in   read addresses, ports A and B
//   PA, PB    out  read data, ports A and B (combinational)
//   rsv_en    in   reserve a destination register (instruction issued)
//   rsv_addr  in   register to mark busy
//   busy_a    out  register RA has a pending write
//   busy_b    out  register RB has a pending write
//   busy_any  out  OR of all busy bits
//
// Modports: master = pipeline side, slave = register file.
// -----------------------------------------------------------------------------
interface param_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              enable;
    logic [ADDR_W-1:0] RW;
    logic [DATA_W-1:0] PW;
    logic [ADDR_W-1:0] RA;
    logic [ADDR_W-1:0] RB;
    logic [DATA_W-1:0] PA;
    logic [DATA_W-1:0] PB;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              busy_a;
    logic              busy_b;
    logic              busy_any;

    modport master (
        output enable, RW, PW, RA, RB, rsv_en, rsv_addr,
        input  PA, PB, busy_a, busy_b, busy_any
    );

    modport slave (
        input  enable, RW, PW, RA, RB, rsv_en, rsv_addr,
        output PA, PB, busy_a, busy_b, busy_any
    );
endinterface

// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
// Parametrised PPU register file with two combinational read ports, one
// write port and a per-register busy scoreboard used by decode to detect
// RAW hazards (issue reserves the destination, writeback clears it).
//
// Parameters:
//   DATA_W    register / data bus width
//   ADDR_W    address width; depth is 2**ADDR_W
//   ZERO_REG  1 = register 0 is hardwired to zero and never goes busy
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (clears all data and busy bits)
//   bus   param_register_file_if.slave (write port, read ports, scoreboard)
//
// Optional feature macro: PRF_WRITE_BYPASS_EN
//   When defined, a write in flight to the address being read is forwarded
//   to PA/PB in the same cycle, and the matching busy_a/busy_b is masked.
// -----------------------------------------------------------------------------
module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    param_register_file_if.slave  bus
);
    localparam int NREGS   = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic              wr_ok;
    logic              rsv_ok;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Writes and reservations to r0 are dropped when it is hardwired.
    assign wr_ok  = bus.enable && !(ZERO_EN && (bus.RW == '0));
    assign rsv_ok = bus.rsv_en && !(ZERO_EN && (bus.rsv_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.RW] <= bus.PW;
        end
    end

    // Clear first, then set: a reservation in the same cycle as the
    // writeback of the same register belongs to the newer instruction.
    always_comb begin
        busy_next = busy;
        if (bus.enable) begin
            busy_next[bus.RW] = 1'b0;
        end
        if (rsv_ok) begin
            busy_next[bus.rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rd_a = (ZERO_EN && (bus.RA == '0)) ? '0 : regs[bus.RA];
    assign rd_b = (ZERO_EN && (bus.RB == '0)) ? '0 : regs[bus.RB];

`ifdef PRF_WRITE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // Forwarding is held off during reset so the outputs read zero.
    assign fwd_a = !rst && wr_ok && (bus.RW == bus.RA);
    assign fwd_b = !rst && wr_ok && (bus.RW == bus.RB);

    assign bus.PA     = fwd_a ? bus.PW : rd_a;
    assign bus.PB     = fwd_b ? bus.PW : rd_b;
    assign bus.busy_a = busy[bus.RA] & ~fwd_a;
    assign bus.busy_b = busy[bus.RB] & ~fwd_b;
`else
    assign bus.PA     = rd_a;
    assign bus.PB     = rd_b;
    assign bus.busy_a = busy[bus.RA];
    assign bus.busy_b = busy[bus.RB];
`endif

    assign bus.busy_any = |busy;
endmodule

// File: tb/tb_param_register_file.sv
// -----------------------------------------------------------------------------
// tb_param_register_file
// Directed self-checking bench for param_register_file. Instantiates the
// default build (32x32, hardwired r0) and a 64-bit x 16 build without a
// hardwired r0. Inputs change on the falling edge; outputs are sampled
// either just after an input change (combinational paths) or 1 ns after
// the rising edge (registered state).
// -----------------------------------------------------------------------------
module tb_param_register_file;
    logic clk;
    logic rst;

    int tests = 0;
    int fails = 0;

    param_register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    param_register_file_if #(.DATA_W(64), .ADDR_W(4)) bus64 ();

    param_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    param_register_file #(.DATA_W(64), .ADDR_W(4), .ZERO_REG(0)) u_p (
        .clk (clk),
        .rst (rst),
        .bus (bus64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.enable = 1'b1;
        bus.RW     = a;
        bus.PW     = d;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
    endtask

    task automatic drive_reserve(input logic [4:0] a);
        @(negedge clk);
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = a;
        @(posedge clk);
        #1;
        bus.rsv_en = 1'b0;
    endtask

    function automatic logic [63:0] pat64(input int i);
        return {32'hF00D_0000 + 32'(i), ~(32'h1000_0000 + 32'(i))};
    endfunction

    task automatic test_reset();
        #1;
        tests++;
        if (bus.PA !== 32'h0) begin
            fails++; $display("FAIL reset_pa: got %h expected %h", bus.PA, 32'h0);
        end
        tests++;
        if (bus.busy_any !== 1'b0) begin
            fails++; $display("FAIL reset_busy_any: got %b expected 0", bus.busy_any);
        end
        tests++;
        if (bus64.PA !== 64'h0) begin
            fails++; $display("FAIL reset_pa64: got %h expected 0", bus64.PA);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_write(5'd5, 32'hDEAD_BEEF);
        drive_reserve(5'd5);
        bus.RA = 5'd5;
        #1;
        tests++;
        if (bus.PA !== 32'hDEAD_BEEF || bus.busy_any !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_state: got pa=%h busy_any=%b expected pa=deadbeef busy_any=1",
                     bus.PA, bus.busy_any);
        end
        // Mid-cycle asynchronous reset pulse, well clear of the rising edge.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.PA !== 32'h0) begin
            fails++; $display("FAIL async_reset_pa: got %h expected 0", bus.PA);
        end
        tests++;
        if (bus.busy_any !== 1'b0 || bus.busy_a !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_busy: got busy_any=%b busy_a=%b expected 0 0",
                     bus.busy_any, bus.busy_a);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (bus.PA !== 32'h0 || bus.busy_any !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_release: got pa=%h busy_any=%b expected 0 0",
                     bus.PA, bus.busy_any);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        for (int i = 1; i < 32; i++) begin
            drive_write(5'(i), 32'(20 + i));
        end
        for (int i = 1; i < 32; i++) begin
            bus.RA = 5'(i);
            bus.RB = 5'(31 - i);
            #1;
            exp_a = 32'(20 + i);
            exp_b = (i == 31) ? 32'h0 : 32'(51 - i);
            tests++;
            if (bus.PA !== exp_a) begin
                fails++; $display("FAIL sweep_pa[%0d]: got %h expected %h", i, bus.PA, exp_a);
            end
            tests++;
            if (bus.PB !== exp_b) begin
                fails++; $display("FAIL sweep_pb[%0d]: got %h expected %h", i, bus.PB, exp_b);
            end
        end
        drive_write(5'd0, 32'h0000_0055);
        bus.RA = 5'd0;
        bus.RB = 5'd0;
        #1;
        tests++;
        if (bus.PA !== 32'h0 || bus.PB !== 32'h0) begin
            fails++; $display("FAIL zero_reg: got pa=%h pb=%h expected 0 0", bus.PA, bus.PB);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        bus.RA       = 5'd7;
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd7;
        #1;
        tests++;
        if (bus.busy_a !== 1'b0) begin
            fails++; $display("FAIL sb_before_edge: got %b expected 0", bus.busy_a);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.busy_a !== 1'b1 || bus.busy_any !== 1'b1) begin
            fails++;
            $display("FAIL sb_set: got busy_a=%b busy_any=%b expected 1 1", bus.busy_a, bus.busy_any);
        end
        // Reserving again while already busy keeps the single bit set.
        @(posedge clk);
        #1;
        bus.rsv_en = 1'b0;
        tests++;
        if (bus.busy_a !== 1'b1) begin
            fails++; $display("FAIL sb_rereserve: got %b expected 1", bus.busy_a);
        end
        drive_write(5'd7, 32'h0000_0077);
        tests++;
        if (bus.busy_a !== 1'b0 || bus.busy_any !== 1'b0) begin
            fails++;
            $display("FAIL sb_clear: got busy_a=%b busy_any=%b expected 0 0", bus.busy_a, bus.busy_any);
        end
        tests++;
        if (bus.PA !== 32'h0000_0077) begin
            fails++; $display("FAIL sb_write_data: got %h expected 00000077", bus.PA);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd9;
        bus.enable   = 1'b1;
        bus.RW       = 5'd9;
        bus.PW       = 32'h0000_1234;
        @(posedge clk);
        #1;
        bus.rsv_en = 1'b0;
        bus.enable = 1'b0;
        bus.RA     = 5'd9;
        #1;
        tests++;
        if (bus.PA !== 32'h0000_1234 || bus.busy_a !== 1'b1) begin
            fails++;
            $display("FAIL collision_same: got pa=%h busy_a=%b expected 00001234 1", bus.PA, bus.busy_a);
        end
        // Set and clear on different addresses in one cycle.
        @(negedge clk);
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd12;
        bus.enable   = 1'b1;
        bus.RW       = 5'd9;
        bus.PW       = 32'h0000_5678;
        @(posedge clk);
        #1;
        bus.rsv_en = 1'b0;
        bus.enable = 1'b0;
        bus.RA     = 5'd9;
        bus.RB     = 5'd12;
        #1;
        tests++;
        if (bus.busy_a !== 1'b0 || bus.busy_b !== 1'b1 || bus.PA !== 32'h0000_5678) begin
            fails++;
            $display("FAIL collision_diff: got busy_a=%b busy_b=%b pa=%h expected 0 1 00005678",
                     bus.busy_a, bus.busy_b, bus.PA);
        end
        drive_write(5'd12, 32'h0000_000C);
        tests++;
        if (bus.busy_any !== 1'b0) begin
            fails++; $display("FAIL collision_drain: got busy_any=%b expected 0", bus.busy_any);
        end
        drive_reserve(5'd0);
        tests++;
        if (bus.busy_any !== 1'b0) begin
            fails++; $display("FAIL reserve_r0: got busy_any=%b expected 0", bus.busy_any);
        end
    endtask

    task automatic test_bypass();
        drive_reserve(5'd3);
        @(negedge clk);
        bus.RA     = 5'd3;
        bus.RB     = 5'd3;
        bus.enable = 1'b1;
        bus.RW     = 5'd3;
        bus.PW     = 32'hA5A5_A5A5;
        #1;
`ifdef PRF_WRITE_BYPASS_EN
        tests++;
        if (bus.PA !== 32'hA5A5_A5A5 || bus.PB !== 32'hA5A5_A5A5 || bus.busy_a !== 1'b0) begin
            fails++;
            $display("FAIL bypass_fwd: got pa=%h pb=%h busy_a=%b expected a5a5a5a5 a5a5a5a5 0",
                     bus.PA, bus.PB, bus.busy_a);
        end
`else
        tests++;
        if (bus.PA !== 32'h0000_0017 || bus.PB !== 32'h0000_0017 || bus.busy_a !== 1'b1) begin
            fails++;
            $display("FAIL bypass_old: got pa=%h pb=%h busy_a=%b expected 00000017 00000017 1",
                     bus.PA, bus.PB, bus.busy_a);
        end
`endif
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        tests++;
        if (bus.PA !== 32'hA5A5_A5A5 || bus.busy_a !== 1'b0) begin
            fails++;
            $display("FAIL bypass_after_edge: got pa=%h busy_a=%b expected a5a5a5a5 0", bus.PA, bus.busy_a);
        end
        // A write to hardwired r0 is never forwarded.
        @(negedge clk);
        bus.RA     = 5'd0;
        bus.enable = 1'b1;
        bus.RW     = 5'd0;
        bus.PW     = 32'hFFFF_FFFF;
        #1;
        tests++;
        if (bus.PA !== 32'h0) begin
            fails++; $display("FAIL bypass_r0: got %h expected 0", bus.PA);
        end
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
    endtask

    task automatic test_param();
        logic [63:0] exp_b;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus64.enable = 1'b1;
            bus64.RW     = 4'(i);
            bus64.PW     = pat64(i);
            @(posedge clk);
            #1;
            bus64.enable = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            bus64.RA = 4'(i);
            bus64.RB = 4'(15 - i);
            #1;
            exp_b = pat64(15 - i);
            tests++;
            if (bus64.PA !== pat64(i) || bus64.PB !== exp_b) begin
                fails++;
                $display("FAIL param_read[%0d]: got pa=%h pb=%h expected %h %h",
                         i, bus64.PA, bus64.PB, pat64(i), exp_b);
            end
        end
        @(negedge clk);
        bus64.rsv_en   = 1'b1;
        bus64.rsv_addr = 4'd0;
        bus64.RA       = 4'd0;
        bus64.RB       = 4'd0;
        @(posedge clk);
        #1;
        bus64.rsv_en = 1'b0;
        tests++;
        if (bus64.busy_any !== 1'b1 || bus64.busy_a !== 1'b1 || bus64.busy_b !== 1'b1) begin
            fails++;
            $display("FAIL param_r0_busy: got any=%b a=%b b=%b expected 1 1 1",
                     bus64.busy_any, bus64.busy_a, bus64.busy_b);
        end
        @(negedge clk);
        bus64.enable = 1'b1;
        bus64.RW     = 4'd0;
        bus64.PW     = 64'h0123_4567_89AB_CDEF;
        @(posedge clk);
        #1;
        bus64.enable = 1'b0;
        tests++;
        if (bus64.busy_any !== 1'b0 || bus64.PA !== 64'h0123_4567_89AB_CDEF) begin
            fails++;
            $display("FAIL param_r0_write: got any=%b pa=%h expected 0 0123456789abcdef",
                     bus64.busy_any, bus64.PA);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.RW       = '0;
        bus.PW       = '0;
        bus.RA       = '0;
        bus.RB       = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
        bus64.enable   = 1'b0;
        bus64.RW       = '0;
        bus64.PW       = '0;
        bus64.RA       = '0;
        bus64.RB       = '0;
        bus64.rsv_en   = 1'b0;
        bus64.rsv_addr = '0;

        test_reset();
        test_sweep();
        test_scoreboard();
        test_collision();
        test_bypass();
        test_param();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
